// File: rtl/rv_hazard_fwd_if.sv
// ID/EX-side bundle of the hazard/forwarding unit: issue request, operand
// resolution results, and register-file write-back.
interface rv_hazard_fwd_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
);
  localparam int RW = $clog2(NREG);
  localparam int SW = $clog2(DEPTH+1);

  logic            id_valid;
  logic [RW-1:0]   id_rs1, id_rs2;
  logic            id_rs1_used, id_rs2_used;
  logic [RW-1:0]   id_rd;
  logic            id_wen, id_load;
  logic [XLEN-1:0] id_rs1_rf, id_rs2_rf;
  logic            flush;
  logic [XLEN-1:0] ex_result, mem_result;
  logic            id_ready;
  logic [XLEN-1:0] op_a, op_b;
  logic [SW-1:0]   fwd_a_src, fwd_b_src;
  logic            wb_en;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_wen, id_load,
           id_rs1_rf, id_rs2_rf, flush, ex_result, mem_result,
    input  id_ready, op_a, op_b, fwd_a_src, fwd_b_src, wb_en, wb_rd, wb_data, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_wen, id_load,
           id_rs1_rf, id_rs2_rf, flush, ex_result, mem_result,
    output id_ready, op_a, op_b, fwd_a_src, fwd_b_src, wb_en, wb_rd, wb_data, stall_cnt
  );
endinterface

// File: rtl/rv_hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the in-order RV32I pipeline.
// Shadows every producer in stages 1..DEPTH (1 = EX, DEPTH = WB).
module rv_hazard_fwd_unit #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int DEPTH      = 4,
  parameter int LOAD_STAGE = 2,
  parameter int CNTW       = 16
) (
  input logic           clk,
  input logic           reset,
  rv_hazard_fwd_if.slave io
);
  localparam int RW = $clog2(NREG);
  localparam int SW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [RW-1:0] rd;
    logic          wen;
    logic          ld;
  } stg_t;

  logic [DEPTH:1]  vld_pipe;
  stg_t            stg      [1:DEPTH];
  logic [XLEN-1:0] data_reg [2:DEPTH];
  logic [XLEN-1:0] dat      [1:DEPTH];
  logic [CNTW-1:0] cnt;

  logic [1:0][RW-1:0]   rs;
  logic [1:0]           used, hz;
  logic [1:0][XLEN-1:0] rf, op;
  logic [1:0][SW-1:0]   src;
  logic                 stall, fire;

  assign rs   = {io.id_rs2, io.id_rs1};
  assign used = {io.id_rs2_used, io.id_rs1_used};
  assign rf   = {io.id_rs2_rf, io.id_rs1_rf};

  // Value each stage would forward right now; loads pick up memory data in LOAD_STAGE.
  always_comb begin
    dat[1] = io.ex_result;
    for (int k = 2; k <= DEPTH; k++)
      dat[k] = (stg[k].ld && k == LOAD_STAGE) ? io.mem_result : data_reg[k];
  end

  // Oldest-to-youngest scan so the youngest matching producer overwrites the rest.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      src[j] = '0;
      op[j]  = rf[j];
      hz[j]  = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (used[j] && rs[j] != '0 && vld_pipe[k] && stg[k].wen && stg[k].rd == rs[j]) begin
          hz[j]  = stg[k].ld && (k < LOAD_STAGE);
          src[j] = (stg[k].ld && (k < LOAD_STAGE)) ? '0 : SW'(k);
          op[j]  = (stg[k].ld && (k < LOAD_STAGE)) ? rf[j] : dat[k];
        end
      end
    end
  end

  assign stall = io.id_valid && !io.flush && (|hz);
  assign fire  = io.id_valid && !stall && !io.flush;

  assign io.id_ready  = !stall;
  assign io.op_a      = op[0];
  assign io.op_b      = op[1];
  assign io.fwd_a_src = src[0];
  assign io.fwd_b_src = src[1];
  assign io.wb_en     = vld_pipe[DEPTH] && stg[DEPTH].wen && (stg[DEPTH].rd != '0);
  assign io.wb_rd     = stg[DEPTH].rd;
  assign io.wb_data   = dat[DEPTH];
  assign io.stall_cnt = cnt;

  // The pipe always advances; a stall just shifts a bubble into stage 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      cnt      <= '0;
      for (int k = 1; k <= DEPTH; k++) stg[k] <= '0;
      for (int k = 2; k <= DEPTH; k++) data_reg[k] <= '0;
    end else begin
      vld_pipe <= {vld_pipe[DEPTH-1:1], fire};
      stg[1]   <= '{rd: io.id_rd, wen: io.id_wen, ld: io.id_load};
      for (int k = 1; k < DEPTH; k++) begin
        stg[k+1]      <= stg[k];
        data_reg[k+1] <= dat[k];
      end
      if (stall && !(&cnt)) cnt <= cnt + 1'b1;
    end
  end
endmodule
